// File: rtl/spi_controller.sv
// Mode-0, MSB-first SPI initiator sending 16-bit {rw, addr, data} register-write frames.
// Optional one-entry request buffer enabled with `define SPI_CTRL_QUEUE_EN.
module spi_controller #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       nCS,
    output logic       SCLK,
    output logic       COPI
);

    localparam int unsigned PH_MAX = (CS_SETUP > CS_HOLD)
                                   ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                   : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int unsigned HALF_W = $clog2(CLK_DIV);

    generate
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("spi_controller: CLK_DIV must be 2 or more");
        end
        if (CS_SETUP < 1 || CS_HOLD < 1) begin : g_bad_cs_timing
            $error("spi_controller: CS_SETUP and CS_HOLD must be 1 or more");
        end
        if (CS_GAP < 2) begin : g_bad_cs_gap
            $error("spi_controller: CS_GAP must be 2 or more");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [3:0]          bit_q, bit_d;
    logic [15:0]         shreg_q, shreg_d;
    logic                ncs_q, ncs_d;
    logic                sclk_q, sclk_d;
    logic                done_q, done_d;
    logic                accept;
    logic                launch;
    logic [15:0]         launch_frame;

`ifdef SPI_CTRL_QUEUE_EN
    logic                pend_valid_q, pend_valid_d;
    logic [15:0]         pend_data_q, pend_data_d;

    assign ready = !pend_valid_q;
`else
    assign ready = (state_q == IDLE);
`endif

    assign accept = start && ready;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign nCS    = ncs_q;
    assign SCLK   = sclk_q;
    // COPI is the shift register MSB; it is cleared in GAP/IDLE so the pin rests low.
    assign COPI   = shreg_q[15];

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        half_d       = half_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        ncs_d        = ncs_q;
        sclk_d       = sclk_q;
        done_d       = 1'b0;
        launch       = 1'b0;
        launch_frame = {rw, addr, wdata};
`ifdef SPI_CTRL_QUEUE_EN
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        if (accept && state_q != IDLE) begin
            pend_valid_d = 1'b1;
            pend_data_d  = {rw, addr, wdata};
        end
`endif
        case (state_q)
            IDLE: begin
`ifdef SPI_CTRL_QUEUE_EN
                if (pend_valid_q) begin
                    launch       = 1'b1;
                    launch_frame = pend_data_q;
                    pend_valid_d = 1'b0;
                end else
`endif
                if (accept) launch = 1'b1;
            end
            SETUP: begin
                if (phase_q == PH_W'(CS_SETUP - 1)) begin
                    state_d = SHIFT;
                    half_d  = '0;
                    bit_d   = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            SHIFT: begin
                if (half_q == HALF_W'(CLK_DIV - 1)) begin
                    half_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: data only moves here, keeping COPI stable while SCLK is high.
                        sclk_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            state_d = HOLD;
                            phase_d = '0;
                        end else begin
                            bit_d   = bit_q + 4'd1;
                            shreg_d = {shreg_q[14:0], 1'b0};
                        end
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            HOLD: begin
                if (phase_q == PH_W'(CS_HOLD - 1)) begin
                    state_d = GAP;
                    phase_d = '0;
                    ncs_d   = 1'b1;
                    shreg_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            GAP: begin
                if (phase_q == PH_W'(CS_GAP - 1)) begin
                    done_d = 1'b1;
`ifdef SPI_CTRL_QUEUE_EN
                    if (pend_valid_q) begin
                        launch       = 1'b1;
                        launch_frame = pend_data_q;
                        pend_valid_d = 1'b0;
                    end else
`endif
                    state_d = IDLE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (launch) begin
            state_d = SETUP;
            phase_d = '0;
            shreg_d = launch_frame;
            ncs_d   = 1'b0;
            sclk_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            half_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            ncs_q   <= ncs_d;
            sclk_q  <= sclk_d;
            done_q  <= done_d;
        end
    end

`ifdef SPI_CTRL_QUEUE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
        end
    end
`endif

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- SPI initiator that drives the register-write frames the on-chip SPI peripheral receives: nCS, SCLK, COPI. Mode 0, MSB first.
- Each frame is 16 bits: {rw, addr[6:0], data[7:0]}, with bit15 sent first; rw=1 means write.
- Sits in test/bring-up logic or a host-side wrapper and turns a parallel request into one framed transfer.
- Timing is generated from the system clock, with margins sized for a receiver that 2-flop-synchronises all SPI inputs.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period. Legal range is 2 or more; values below 2 are a compile-time error.
- CS_SETUP, 4: clk cycles from nCS falling to the first SCLK rise. Minimum 1.
- CS_HOLD, 4: clk cycles from the last SCLK fall to nCS rising. Minimum 1.
- CS_GAP, 4: minimum clk cycles nCS stays high between frames. Minimum 2.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, synchronous, active-high.
- start, input, 1: request strobe. Accepted when start && ready at a clk edge.
- rw, input, 1: frame bit15.
- addr, input, 7: frame bits 14:8.
- wdata, input, 8: frame bits 7:0.
- ready, output, 1: controller can accept a request.
- busy, output, 1: a frame is in progress.
- done, output, 1: one-cycle pulse when a frame completes.
- nCS, output, 1: chip select, active-low.
- SCLK, output, 1: serial clock, idles low.
- COPI, output, 1: serial data to the peripheral.

Behaviour:
- Reset (rst high at a clk edge): state returns to IDLE, counters clear. Outputs after that edge: nCS=1, SCLK=0, COPI=0, busy=0, done=0, ready=1.
- Reset mid-frame aborts the frame immediately, with no hold or gap phase and no done pulse.
- Every SPI output is driven directly from a flop, with no combinational paths to the pins.
- Accept: on the edge that samples start && ready, {rw, addr, wdata} are latched into a 16-bit shift register. Input changes afterwards are ignored until the next accept.
- start while not ready is dropped (base build).
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - nCS=1, SCLK=0, ready=1, busy=0.
  - On accept, go to SETUP. From the next cycle: nCS=0, COPI=bit15, busy=1, ready=0.
- SETUP:
  - Lasts CS_SETUP cycles, with SCLK=0 throughout.
  - Then go to SHIFT.
- SHIFT:
  - Carries 16 bits. Each bit is CLK_DIV cycles of SCLK=0 followed by CLK_DIV cycles of SCLK=1.
  - COPI changes only at SCLK falling edges, so it is stable for the whole high phase.
  - At a falling edge that is not the last, the shift register advances and COPI takes the next bit.
  - A 4-bit bit counter plus a half-period counter sized to CLK_DIV are required.
  - After the 16th falling edge (SCLK returns to 0), go to HOLD.
- HOLD:
  - Lasts CS_HOLD cycles with nCS=0 and SCLK=0. COPI holds the last bit (data[0]).
  - Then go to GAP.
- GAP:
  - Lasts CS_GAP cycles with nCS=1 and COPI=0.
  - Then go to IDLE.
- done:
  - High for exactly one cycle, in the first IDLE cycle after GAP. In that cycle busy=0 and ready=1.
  - An accept in the done cycle is legal.
- Frame latency with defaults, taking the accept edge as cycle 0:
  - nCS low in cycles 1..136.
  - 16 SCLK rises; the first rise is at cycle 9.
  - nCS high from cycle 137; done at cycle 141.
  - General form: done at 1 + CS_SETUP + 32*CLK_DIV + CS_HOLD + CS_GAP.
- Exactly 16 SCLK rising edges per frame. SCLK never toggles while nCS=1.
- rw=0 frames are transmitted identically; the peripheral ignores them.

Optional Feature:
- Macro: SPI_CTRL_QUEUE_EN.
- When defined: a one-entry pending buffer is added.
  - ready = !pending_valid.
  - An accept while busy stores the request in the buffer.
  - On leaving GAP with pending_valid set, the controller goes straight to SETUP with the pending request instead of IDLE, and clears pending_valid. done still pulses for one cycle on that transition; busy stays 1.
  - Reset clears pending_valid.
- When undefined: no buffer, and ready = (state == IDLE).

Test Plan:
- Reset then idle: after rst, nCS=1, SCLK=0, COPI=0, ready=1, busy=0, done=0 for 20 cycles with start=0.
- Single write, rw=1, addr=7'h04, wdata=8'hA5: bit-bang monitor captures 16'h84A5, exactly 16 SCLK rises, done at cycle 141, nCS low for exactly 136 cycles.
- Loop through the peripheral: writes to addr 0..4 with data 8'h01, 8'h80, 8'hFF, 8'h3C, 8'h7F; after each done, the matching peripheral register holds that value.
- start pulsed every cycle during a frame (base build): only the first request is sent, and ready=0 throughout busy. Under SPI_CTRL_QUEUE_EN, exactly two frames are sent back-to-back, separated by a CS_GAP high gap.
- rst asserted at cycle 60 of a frame: next cycle nCS=1, SCLK=0, busy=0, and no done. A following frame with 16'h8155 is received intact.
- CLK_DIV=2, CS_GAP=2 build: frame 16'h8312 is transferred correctly and the peripheral register at addr 3 reads 8'h12.
